strip_xg_pon_header: RTL and testbench

// - Burst receiver and delineator. Takes raw 32-bit words from the GTH-10G receiver (no encoding) and

---
 rtl/strip_xg_pon_header.sv | 201 ++++++++++++++++++++
 tb/tb_strip_xg_pon_header.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/strip_xg_pon_header.sv
// Burst receiver/delineator: hunts preamble and delimiter at any bit offset in the raw GTH word
// stream, locks alignment, and re-emits the payload as a push-only 32-bit AXI-Stream.
module strip_xg_pon_header #(
    parameter int unsigned MAX_BURST_WORDS = 4096,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             axis_clk,
    input  logic             axis_resetn,
    input  logic             enable,
    input  logic [31:0]      rx_data,
    input  logic             rx_valid,
    input  logic [31:0]      preamble_pattern,
    input  logic [31:0]      delimiter_pattern,
    input  logic [31:0]      frtrail_pattern,
    input  logic [7:0]       preamble_min,
    output logic [31:0]      axis_TDATA_out,
    output logic             axis_TVALID_out,
    output logic [3:0]       axis_TKEEP_out,
    output logic             axis_TLAST_out,
    output logic             axis_TUSER_out,
    output logic             locked,
    output logic [4:0]       bit_offset,
    output logic             burst_done,
    output logic             burst_err,
    output logic [CNT_W-1:0] burst_count
);

    localparam int unsigned BeatW = $clog2(MAX_BURST_WORDS + 1);

    typedef enum logic [1:0] {StIdle, StHunt, StPayload} state_e;

    state_e             state_q, state_d;
    logic [31:0]        prev_q, prev_d;
    logic [7:0]         pre_cnt_q, pre_cnt_d;
    logic [4:0]         off_q, off_d;
    logic [31:0]        hold_q, hold_d;
    logic               hold_vld_q, hold_vld_d;
    logic [BeatW-1:0]   beat_q, beat_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        tdata_q, tdata_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic               tuser_q, tuser_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [63:0]        win;
    logic [31:0]        w;
    logic               pre_hit, del_hit, trl_hit, accept, timeout;
    logic [4:0]         del_k;

    // prev_q holds the older word, so cand(0) is the previous valid word
    assign win     = {rx_data, prev_q};
    assign w       = win[off_q +: 32];
    assign trl_hit = (w == frtrail_pattern);
    assign accept  = (pre_cnt_q >= preamble_min) && del_hit;
    assign timeout = hold_vld_q && (beat_q == BeatW'(MAX_BURST_WORDS));

    // Descending scan so the lowest matching offset wins
    always_comb begin
        pre_hit = 1'b0;
        del_hit = 1'b0;
        del_k   = '0;
        for (int k = 31; k >= 0; k--) begin
            if (win[k +: 32] == preamble_pattern) pre_hit = 1'b1;
            if (win[k +: 32] == delimiter_pattern) begin
                del_hit = 1'b1;
                del_k   = 5'(k);
            end
        end
    end

    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) state_q <= StIdle;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:    if (rx_valid && pre_hit) state_d = StHunt;
                StHunt: begin
                    if (!rx_valid)    state_d = StIdle;
                    else if (pre_hit) state_d = StHunt;
                    else if (accept)  state_d = StPayload;
                    else              state_d = StIdle;
                end
                StPayload: if (!rx_valid || trl_hit || timeout) state_d = StIdle;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        prev_d     = rx_valid ? rx_data : prev_q;
        pre_cnt_d  = pre_cnt_q;
        off_d      = off_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        beat_d     = beat_q;
        cnt_d      = cnt_q;
        tdata_d    = '0;
        tvalid_d   = 1'b0;
        tlast_d    = 1'b0;
        tuser_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            StIdle: begin
                hold_vld_d = 1'b0;
                if (enable && rx_valid && pre_hit) pre_cnt_d = 8'd1;
            end
            StHunt: begin
                if (enable && rx_valid) begin
                    if (pre_hit) begin
                        pre_cnt_d = (pre_cnt_q == 8'hFF) ? pre_cnt_q : pre_cnt_q + 8'd1;
                    end else if (accept) begin
                        off_d      = del_k;
                        beat_d     = '0;
                        hold_vld_d = 1'b0;
                    end
                end
            end
            StPayload: begin
                tdata_d  = hold_vld_q ? hold_q : '0;
                tvalid_d = hold_vld_q;
                if (!enable || !rx_valid) begin
                    // Abort outranks a trailer seen in the same cycle
                    tlast_d    = hold_vld_q;
                    tuser_d    = hold_vld_q;
                    err_d      = 1'b1;
                    hold_vld_d = 1'b0;
                end else if (trl_hit) begin
                    tlast_d    = hold_vld_q;
                    done_d     = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                    hold_vld_d = 1'b0;
                end else if (timeout) begin
                    tlast_d    = 1'b1;
                    tuser_d    = 1'b1;
                    err_d      = 1'b1;
                    hold_vld_d = 1'b0;
                end else begin
                    if (hold_vld_q) beat_d = beat_q + BeatW'(1);
                    hold_d     = w;
                    hold_vld_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            prev_q     <= '0;
            pre_cnt_q  <= '0;
            off_q      <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            beat_q     <= '0;
            cnt_q      <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            pre_cnt_q  <= pre_cnt_d;
            off_q      <= off_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            beat_q     <= beat_d;
            cnt_q      <= cnt_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tuser_q    <= tuser_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        axis_TDATA_out  = tdata_q;
        axis_TVALID_out = tvalid_q;
        axis_TKEEP_out  = {4{tvalid_q}};
        axis_TLAST_out  = tlast_q;
        axis_TUSER_out  = tuser_q;
        locked          = (state_q == StPayload);
        bit_offset      = off_q;
        burst_done      = done_q;
        burst_err       = err_q;
        burst_count     = cnt_q;
    end

endmodule

// File: tb/tb_strip_xg_pon_header.sv
// Directed table-driven bench for strip_xg_pon_header: each row is one rx word plus the outputs
// expected right after the clock edge that consumes it.
module tb_strip_xg_pon_header;

    localparam logic [31:0] PRE = 32'h05560556;
    localparam logic [31:0] DEL = 32'hB2C50FA1;
    localparam logic [31:0] TRL = 32'h82D6F416;
    localparam logic [31:0] P1  = 32'h11111111;
    localparam logic [31:0] P2  = 32'h22222222;
    localparam logic [31:0] P3  = 32'h33333333;

    logic        axis_clk = 1'b0;
    logic        axis_resetn = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  preamble_min = 8'd3;
    logic [31:0] axis_TDATA_out;
    logic        axis_TVALID_out;
    logic [3:0]  axis_TKEEP_out;
    logic        axis_TLAST_out;
    logic        axis_TUSER_out;
    logic        locked;
    logic [4:0]  bit_offset;
    logic        burst_done;
    logic        burst_err;
    logic [15:0] burst_count;

    strip_xg_pon_header #(
        .MAX_BURST_WORDS(8),
        .CNT_W          (16)
    ) dut (
        .axis_clk         (axis_clk),
        .axis_resetn      (axis_resetn),
        .enable           (enable),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .preamble_pattern (PRE),
        .delimiter_pattern(DEL),
        .frtrail_pattern  (TRL),
        .preamble_min     (preamble_min),
        .axis_TDATA_out   (axis_TDATA_out),
        .axis_TVALID_out  (axis_TVALID_out),
        .axis_TKEEP_out   (axis_TKEEP_out),
        .axis_TLAST_out   (axis_TLAST_out),
        .axis_TUSER_out   (axis_TUSER_out),
        .locked           (locked),
        .bit_offset       (bit_offset),
        .burst_done       (burst_done),
        .burst_err        (burst_err),
        .burst_count      (burst_count)
    );

    always #5 axis_clk = ~axis_clk;

    typedef struct {
        logic [31:0] data;
        logic        vld;
        logic        en;
        logic        tv;
        logic [31:0] td;
        logic        tl;
        logic        tu;
        logic        done;
        logic        err;
        logic        lock;
    } row_t;

    row_t rows[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] d, input logic v, input logic en, input logic tv,
                       input logic [31:0] td, input logic tl, input logic tu, input logic done,
                       input logic err, input logic lock);
        row_t r;
        r.data = d; r.vld = v; r.en = en; r.tv = tv; r.td = td;
        r.tl = tl; r.tu = tu; r.done = done; r.err = err; r.lock = lock;
        rows.push_back(r);
    endtask

    // Row with no beat and no pulse expected
    task automatic addn(input logic [31:0] d, input logic lock);
        add(d, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, lock);
    endtask

    task automatic flush();
        addn(32'h0, 1'b0);
        addn(32'h0, 1'b0);
    endtask

    task automatic run_rows(input string tag);
        foreach (rows[i]) begin
            rx_data  = rows[i].data;
            rx_valid = rows[i].vld;
            enable   = rows[i].en;
            @(posedge axis_clk);
            #1;
            chk($sformatf("%s[%0d].tvalid", tag, i), 32'(axis_TVALID_out), 32'(rows[i].tv));
            chk($sformatf("%s[%0d].tkeep", tag, i), 32'(axis_TKEEP_out),
                rows[i].tv ? 32'hF : 32'h0);
            if (rows[i].tv) begin
                chk($sformatf("%s[%0d].tdata", tag, i), axis_TDATA_out, rows[i].td);
                chk($sformatf("%s[%0d].tlast", tag, i), 32'(axis_TLAST_out), 32'(rows[i].tl));
                chk($sformatf("%s[%0d].tuser", tag, i), 32'(axis_TUSER_out), 32'(rows[i].tu));
            end
            chk($sformatf("%s[%0d].done", tag, i), 32'(burst_done), 32'(rows[i].done));
            chk($sformatf("%s[%0d].err", tag, i), 32'(burst_err), 32'(rows[i].err));
            chk($sformatf("%s[%0d].locked", tag, i), 32'(locked), 32'(rows[i].lock));
        end
        rows.delete();
    endtask

    // Nominal burst; sh shifts the serial stream by sh bits (words then sit at offset sh)
    task automatic build_basic(input int sh, input int n);
        logic [31:0] w[10];
        logic [31:0] x[10];
        w = '{PRE, PRE, PRE, DEL, P1, P2, P3, TRL, 32'h0, 32'h0};
        for (int i = 0; i < 10; i++) begin
            if (sh == 0) x[i] = w[i];
            else x[i] = (w[i] << sh) | ((i == 0 ? 32'h0 : w[i-1]) >> (32 - sh));
        end
        if (n > 0) addn(x[0], 1'b0);
        if (n > 1) addn(x[1], 1'b0);
        if (n > 2) addn(x[2], 1'b0);
        if (n > 3) addn(x[3], 1'b0);
        if (n > 4) addn(x[4], 1'b1);
        if (n > 5) addn(x[5], 1'b1);
        if (n > 6) add(x[6], 1'b1, 1'b1, 1'b1, P1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        if (n > 7) add(x[7], 1'b1, 1'b1, 1'b1, P2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        if (n > 8) add(x[8], 1'b1, 1'b1, 1'b1, P3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        if (n > 9) addn(x[9], 1'b0);
    endtask

    initial begin
        logic [31:0] pw;
        // Reset state
        repeat (2) @(posedge axis_clk);
        #1;
        chk("rst.tvalid", 32'(axis_TVALID_out), 32'h0);
        chk("rst.tkeep", 32'(axis_TKEEP_out), 32'h0);
        chk("rst.tdata", axis_TDATA_out, 32'h0);
        chk("rst.locked", 32'(locked), 32'h0);
        chk("rst.count", 32'(burst_count), 32'h0);
        @(negedge axis_clk);
        axis_resetn = 1'b1;

        // Test 1: nominal burst at offset 0
        flush();
        build_basic(0, 10);
        run_rows("t1");
        chk("t1.count", 32'(burst_count), 32'd1);
        chk("t1.offset", 32'(bit_offset), 32'd0);

        // Test 2: same stream shifted by 13 bits
        flush();
        build_basic(13, 10);
        run_rows("t2");
        chk("t2.count", 32'(burst_count), 32'd2);
        chk("t2.offset", 32'(bit_offset), 32'd13);

        // Test 3: preamble too short
        preamble_min = 8'd4;
        flush();
        addn(PRE, 1'b0); addn(PRE, 1'b0); addn(PRE, 1'b0); addn(DEL, 1'b0);
        addn(P1, 1'b0); addn(P2, 1'b0); addn(P3, 1'b0); addn(TRL, 1'b0);
        addn(32'h0, 1'b0); addn(32'h0, 1'b0);
        run_rows("t3");
        chk("t3.count", 32'(burst_count), 32'd2);
        preamble_min = 8'd3;

        // Test 4: rx_valid drops after two payload words
        flush();
        addn(PRE, 1'b0); addn(PRE, 1'b0); addn(PRE, 1'b0); addn(DEL, 1'b0);
        addn(P1, 1'b1); addn(P2, 1'b1);
        add(P3, 1'b1, 1'b1, 1'b1, P1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(32'h0, 1'b0, 1'b1, 1'b1, P2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        flush();
        run_rows("t4");
        chk("t4.count", 32'(burst_count), 32'd2);

        // Test 4b: enable drop on the same cycle the trailer is seen; abort wins
        flush();
        addn(PRE, 1'b0); addn(PRE, 1'b0); addn(PRE, 1'b0); addn(DEL, 1'b0);
        addn(P1, 1'b1); addn(TRL, 1'b1);
        add(32'h0, 1'b1, 1'b0, 1'b1, P1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        flush();
        run_rows("t4b");
        chk("t4b.count", 32'(burst_count), 32'd2);

        // Test 5: timeout after 8 beats of a 20-word payload, then an empty burst
        flush();
        addn(PRE, 1'b0); addn(PRE, 1'b0); addn(PRE, 1'b0); addn(DEL, 1'b0);
        for (int n = 0; n < 20; n++) begin
            pw = 32'hA000_0000 + 32'(n);
            if (n < 2) addn(pw, 1'b1);
            else if (n < 10)
                add(pw, 1'b1, 1'b1, 1'b1, 32'hA000_0000 + 32'(n - 2), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            else if (n == 10)
                add(pw, 1'b1, 1'b1, 1'b1, 32'hA000_0008, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            else addn(pw, 1'b0);
        end
        addn(PRE, 1'b0); addn(PRE, 1'b0); addn(PRE, 1'b0); addn(DEL, 1'b0);
        addn(TRL, 1'b1);
        add(32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        addn(32'h0, 1'b0);
        run_rows("t5");
        chk("t5.count", 32'(burst_count), 32'd3);

        // Test 6: asynchronous reset mid-payload, then a normal burst
        flush();
        build_basic(0, 7);
        run_rows("t6a");
        #2;
        axis_resetn = 1'b0;
        #1;
        chk("t6.tvalid", 32'(axis_TVALID_out), 32'h0);
        chk("t6.tkeep", 32'(axis_TKEEP_out), 32'h0);
        chk("t6.tdata", axis_TDATA_out, 32'h0);
        chk("t6.tlast", 32'(axis_TLAST_out), 32'h0);
        chk("t6.tuser", 32'(axis_TUSER_out), 32'h0);
        chk("t6.locked", 32'(locked), 32'h0);
        chk("t6.offset", 32'(bit_offset), 32'h0);
        chk("t6.done", 32'(burst_done), 32'h0);
        chk("t6.err", 32'(burst_err), 32'h0);
        chk("t6.count", 32'(burst_count), 32'h0);
        @(negedge axis_clk);
        axis_resetn = 1'b1;
        flush();
        build_basic(0, 10);
        run_rows("t6b");
        chk("t6b.count", 32'(burst_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
